mem_port_arbiter: RTL and testbench

//  Shares the single-port instruction RAM (9-bit addr, 32-bit word, 1-cycle registered read)

---
 rtl/mem_port_arbiter.sv | 143 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port instruction RAM between the host loader and the fetch unit.
// An IDLE/RUN/DRAIN sequencer selects which port may be granted. Read data comes back in grant order.
module mem_port_arbiter #(
  parameter int AW           = 9,
  parameter int DW           = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          working,
  input  logic          host_req,
  input  logic          host_wr,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic          host_rvalid,
  output logic [DW-1:0] host_rdata,
  input  logic          fetch_req,
  input  logic [AW-1:0] fetch_addr,
  output logic          fetch_gnt,
  output logic          fetch_rvalid,
  output logic [DW-1:0] fetch_rdata,
  output logic [AW-1:0] ram_addr,
  output logic          ram_wr,
  output logic [DW-1:0] ram_wdata,
  output logic          ram_rd,
  input  logic [DW-1:0] ram_rdata,
  output logic          busy,
  output logic [1:0]    dbg_state
);

  // Handshake (both ports): a transfer happens at a posedge where req and gnt are both high.
  // The requester holds its address/data stable until gnt; gnt never depends on the held data.

  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DRAIN = 2'd2} state_e;
  typedef enum logic [1:0] {TAG_NONE = 2'd0, TAG_HOST = 2'd1, TAG_FETCH = 2'd2} tag_e;

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  state_e        state_q, state_d;
  tag_e          tag1_q, tag1_d, tag2_q, tag2_d;
  logic [7:0]    starve_q, starve_d;
  logic [AW-1:0] ram_addr_q, ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic          ram_wr_q, ram_wr_d;
  logic          ram_rd_q, ram_rd_d;
  logic          starve_hit;

  always_comb begin
    host_gnt   = 1'b0;
    fetch_gnt  = 1'b0;
    starve_hit = (starve_q == LIMIT);
    case (state_q)
      ST_IDLE: host_gnt = host_req;
      ST_RUN: begin
        host_gnt  = host_req && (!fetch_req || starve_hit);
        fetch_gnt = fetch_req && !host_gnt;
      end
      default: ;
    endcase
    // Grants are held off for the whole time reset is asserted.
    if (!rst_n) begin
      host_gnt  = 1'b0;
      fetch_gnt = 1'b0;
    end
  end

  always_comb begin
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    ram_wr_d    = 1'b0;
    ram_rd_d    = 1'b0;
    tag1_d      = TAG_NONE;
    tag2_d      = tag1_q;
    starve_d    = starve_q;
    state_d     = state_q;

    if (host_gnt) begin
      ram_addr_d = host_addr;
      if (host_wr) begin
        ram_wr_d    = 1'b1;
        ram_wdata_d = host_wdata;
      end else begin
        ram_rd_d = 1'b1;
        tag1_d   = TAG_HOST;
      end
    end else if (fetch_gnt) begin
      ram_addr_d = fetch_addr;
      ram_rd_d   = 1'b1;
      tag1_d     = TAG_FETCH;
    end

    if (!host_req || host_gnt) begin
      starve_d = 8'd0;
    end else if (fetch_gnt && !starve_hit) begin
      starve_d = starve_q + 8'd1;
    end

    case (state_q)
      ST_IDLE:  if (working) state_d = ST_RUN;
      ST_RUN:   if (!working) state_d = ST_DRAIN;
      ST_DRAIN: begin
        if (working) state_d = ST_RUN;
        else if (tag1_q == TAG_NONE && tag2_q == TAG_NONE) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      tag1_q      <= TAG_NONE;
      tag2_q      <= TAG_NONE;
      starve_q    <= 8'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      ram_wr_q    <= 1'b0;
      ram_rd_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      tag1_q      <= tag1_d;
      tag2_q      <= tag2_d;
      starve_q    <= starve_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      ram_wr_q    <= ram_wr_d;
      ram_rd_q    <= ram_rd_d;
    end
  end

  assign ram_addr     = ram_addr_q;
  assign ram_wdata    = ram_wdata_q;
  assign ram_wr       = ram_wr_q;
  assign ram_rd       = ram_rd_q;
  assign host_rvalid  = (tag2_q == TAG_HOST);
  assign fetch_rvalid = (tag2_q == TAG_FETCH);
  assign host_rdata   = ram_rdata;
  assign fetch_rdata  = ram_rdata;
  assign busy         = (state_q != ST_IDLE) || (tag1_q != TAG_NONE) || (tag2_q != TAG_NONE);
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural RAM, per-port expected-data queues, scenario tasks.
module tb_mem_port_arbiter;
  localparam int AW    = 9;
  localparam int DW    = 32;
  localparam int LIMIT = 8;

  logic          clock = 1'b0;
  logic          rst_n;
  logic          working;
  logic          host_req, host_wr;
  logic [AW-1:0] host_addr;
  logic [DW-1:0] host_wdata;
  logic          host_gnt, host_rvalid;
  logic [DW-1:0] host_rdata;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_gnt, fetch_rvalid;
  logic [DW-1:0] fetch_rdata;
  logic [AW-1:0] ram_addr;
  logic          ram_wr, ram_rd;
  logic [DW-1:0] ram_wdata;
  logic [DW-1:0] ram_rdata = '0;
  logic          busy;
  logic [1:0]    dbg_state;

  logic [DW-1:0] ram_mem [0:511];
  logic          ram_written [0:511];
  logic [DW-1:0] ref_mem [0:511];
  logic [DW-1:0] host_exp_q[$];
  logic [DW-1:0] fetch_exp_q[$];
  logic [DW-1:0] mon_exp;
  int n_checks = 0;
  int n_fail   = 0;

  always #5 clock = ~clock;

  mem_port_arbiter #(.AW(AW), .DW(DW), .STARVE_LIMIT(LIMIT)) dut (
    .clock(clock), .rst_n(rst_n), .working(working),
    .host_req(host_req), .host_wr(host_wr), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rvalid(host_rvalid), .host_rdata(host_rdata),
    .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
    .fetch_rvalid(fetch_rvalid), .fetch_rdata(fetch_rdata),
    .ram_addr(ram_addr), .ram_wr(ram_wr), .ram_wdata(ram_wdata), .ram_rd(ram_rd),
    .ram_rdata(ram_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  function automatic logic [DW-1:0] pat(input logic [AW-1:0] a);
    return {a, 7'h35, ~a, 7'h4A};
  endfunction

  // Single-port RAM with one-cycle registered read; unwritten words read as pat(addr).
  always @(posedge clock) begin
    if (ram_wr) begin
      ram_mem[ram_addr]     <= ram_wdata;
      ram_written[ram_addr] <= 1'b1;
    end
    if (ram_rd) ram_rdata <= (ram_written[ram_addr] === 1'b1) ? ram_mem[ram_addr] : pat(ram_addr);
  end

  // Response monitor: every rvalid must match the oldest outstanding read of that port.
  always @(negedge clock) begin
    if (rst_n === 1'b1) begin
      if (host_rvalid === 1'b1) begin
        n_checks++;
        if (host_exp_q.size() == 0) begin
          n_fail++; $display("FAIL host_rvalid_unexpected: got rvalid=1 required none outstanding");
        end else begin
          mon_exp = host_exp_q.pop_front();
          if (host_rdata !== mon_exp) begin
            n_fail++; $display("FAIL host_rdata: got %h required %h", host_rdata, mon_exp);
          end
        end
      end
      if (fetch_rvalid === 1'b1) begin
        n_checks++;
        if (fetch_exp_q.size() == 0) begin
          n_fail++; $display("FAIL fetch_rvalid_unexpected: got rvalid=1 required none outstanding");
        end else begin
          mon_exp = fetch_exp_q.pop_front();
          if (fetch_rdata !== mon_exp) begin
            n_fail++; $display("FAIL fetch_rdata: got %h required %h", fetch_rdata, mon_exp);
          end
        end
      end
    end
  end

  task automatic test_reset();
    rst_n = 1'b0; working = 1'b1; host_req = 1'b1; host_wr = 1'b1; fetch_req = 1'b1;
    host_addr = 9'h1AA; host_wdata = 32'hDEADBEEF; fetch_addr = 9'h055;
    repeat (2) @(negedge clock);
    #1;
    n_checks++;
    if ({host_gnt, fetch_gnt} !== 2'b00) begin
      n_fail++; $display("FAIL reset_gnts: got %b required 00", {host_gnt, fetch_gnt});
    end
    n_checks++;
    if ({ram_wr, ram_rd, host_rvalid, fetch_rvalid, busy} !== 5'b0) begin
      n_fail++; $display("FAIL reset_flags: got %b required 00000",
                         {ram_wr, ram_rd, host_rvalid, fetch_rvalid, busy});
    end
    n_checks++;
    if ({ram_addr, ram_wdata, dbg_state} !== '0) begin
      n_fail++; $display("FAIL reset_regs: got addr=%h wdata=%h state=%0d required 0",
                         ram_addr, ram_wdata, dbg_state);
    end
    @(negedge clock);
    host_req = 1'b0; fetch_req = 1'b0; working = 1'b0; rst_n = 1'b1;
    #1;
    n_checks++;
    if ({busy, dbg_state} !== 3'b000) begin
      n_fail++; $display("FAIL reset_release: got busy=%b state=%0d required 0/IDLE", busy, dbg_state);
    end
  endtask

  task automatic test_host_idle();
    @(negedge clock);
    host_req = 1'b1; host_wr = 1'b1; host_addr = 9'h005; host_wdata = 32'h30F2000A;
    #1;
    n_checks++;
    if (host_gnt !== 1'b1) begin n_fail++; $display("FAIL idle_wr_gnt: got %b required 1", host_gnt); end
    if (host_gnt === 1'b1) ref_mem[5] = 32'h30F2000A;
    @(negedge clock);
    host_req = 1'b0;
    #1;
    n_checks++;
    if ({ram_wr, ram_rd, ram_addr, ram_wdata} !== {1'b1, 1'b0, 9'h005, 32'h30F2000A}) begin
      n_fail++; $display("FAIL idle_wr_strobe: got wr=%b rd=%b addr=%h wdata=%h required 1 0 005 30f2000a",
                         ram_wr, ram_rd, ram_addr, ram_wdata);
    end
    @(negedge clock);
    host_req = 1'b1; host_wr = 1'b0; host_addr = 9'h005;
    #1;
    n_checks++;
    if ({host_gnt, ram_wr, ram_addr} !== {1'b1, 1'b0, 9'h005}) begin
      n_fail++; $display("FAIL idle_rd_gnt: got gnt=%b wr=%b addr=%h required 1 0 005",
                         host_gnt, ram_wr, ram_addr);
    end
    if (host_gnt === 1'b1) host_exp_q.push_back(ref_mem[5]);
    @(negedge clock);
    host_req = 1'b0;
    #1;
    n_checks++;
    if ({ram_rd, host_rvalid} !== 2'b10) begin
      n_fail++; $display("FAIL idle_rd_strobe: got rd=%b rvalid=%b required 1 0", ram_rd, host_rvalid);
    end
    @(negedge clock);
    #1;
    n_checks++;
    if ({host_rvalid, ram_rd, ram_addr} !== {1'b1, 1'b0, 9'h005}) begin
      n_fail++; $display("FAIL idle_rd_latency: got rvalid=%b rd=%b addr=%h required 1 0 005",
                         host_rvalid, ram_rd, ram_addr);
    end
  endtask

  task automatic test_fetch_burst();
    @(negedge clock);
    fetch_req = 1'b1; fetch_addr = 9'h000; working = 1'b0;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL idle_fetch_blocked: got %b required 0", fetch_gnt); end
    @(negedge clock);
    working = 1'b1;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b0) begin n_fail++; $display("FAIL idle_fetch_old_state: got %b required 0", fetch_gnt); end
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      fetch_addr = 9'(i);
      #1;
      n_checks++;
      if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL burst_gnt[%0d]: got %b required 1", i, fetch_gnt); end
      if (fetch_gnt === 1'b1) fetch_exp_q.push_back(ref_mem[i]);
      if (i >= 2) begin
        n_checks++;
        if (fetch_rvalid !== 1'b1) begin
          n_fail++; $display("FAIL burst_rvalid[%0d]: got %b required 1", i - 2, fetch_rvalid);
        end
      end
    end
    @(negedge clock);
    fetch_req = 1'b0;
    #1;
    n_checks++;
    if (fetch_rvalid !== 1'b1) begin n_fail++; $display("FAIL burst_rvalid[2]: got %b required 1", fetch_rvalid); end
    @(negedge clock);
    #1;
    n_checks++;
    if (fetch_rvalid !== 1'b1) begin n_fail++; $display("FAIL burst_rvalid[3]: got %b required 1", fetch_rvalid); end
    @(negedge clock);
    #1;
    n_checks++;
    if (fetch_rvalid !== 1'b0) begin n_fail++; $display("FAIL burst_rvalid_end: got %b required 0", fetch_rvalid); end
  endtask

  task automatic test_starvation();
    int sc = 0;
    logic exp_host;
    for (int c = 0; c < 27; c++) begin
      @(negedge clock);
      host_req = 1'b1; host_wr = 1'b0; host_addr = 9'h005;
      fetch_req = 1'b1; fetch_addr = 9'($urandom_range(0, 511));
      #1;
      exp_host = (sc == LIMIT);
      n_checks++;
      if ({host_gnt, fetch_gnt} !== {exp_host, ~exp_host}) begin
        n_fail++; $display("FAIL starve_pattern[%0d]: got host=%b fetch=%b required host=%b fetch=%b",
                           c, host_gnt, fetch_gnt, exp_host, ~exp_host);
      end
      if (host_gnt === 1'b1) host_exp_q.push_back(ref_mem[5]);
      if (fetch_gnt === 1'b1) fetch_exp_q.push_back(ref_mem[fetch_addr]);
      if (exp_host) sc = 0;
      else if (sc < LIMIT) sc++;
    end
    @(negedge clock);
    host_req = 1'b0; fetch_req = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  task automatic test_drain();
    bit reached = 1'b0;
    @(negedge clock);
    fetch_req = 1'b1; fetch_addr = 9'($urandom_range(0, 511));
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL drain_gnt0: got %b required 1", fetch_gnt); end
    if (fetch_gnt === 1'b1) fetch_exp_q.push_back(ref_mem[fetch_addr]);
    @(negedge clock);
    fetch_addr = 9'($urandom_range(0, 511)); working = 1'b0;
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL drain_gnt1_old_state: got %b required 1", fetch_gnt); end
    if (fetch_gnt === 1'b1) fetch_exp_q.push_back(ref_mem[fetch_addr]);
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      host_req = 1'b1; host_wr = 1'b0; host_addr = 9'h005;
      #1;
      n_checks++;
      if ({host_gnt, fetch_gnt, busy, fetch_rvalid} !== 4'b0011) begin
        n_fail++; $display("FAIL drain_inflight[%0d]: got hg=%b fg=%b busy=%b rvalid=%b required 0 0 1 1",
                           k, host_gnt, fetch_gnt, busy, fetch_rvalid);
      end
    end
    for (int k = 0; k < 6 && !reached; k++) begin
      @(negedge clock);
      #1;
      if (dbg_state == 2'd0) reached = 1'b1;
      else begin
        n_checks++;
        if ({host_gnt, fetch_gnt} !== 2'b00) begin
          n_fail++; $display("FAIL drain_no_gnt: got host=%b fetch=%b required 00", host_gnt, fetch_gnt);
        end
      end
    end
    n_checks++;
    if (!reached) begin n_fail++; $display("FAIL drain_to_idle: got state=%0d required 0 within 6 cycles", dbg_state); end
    n_checks++;
    if ({busy, host_gnt, fetch_gnt} !== 3'b010) begin
      n_fail++; $display("FAIL drain_idle_resume: got busy=%b hg=%b fg=%b required 0 1 0", busy, host_gnt, fetch_gnt);
    end
    host_req = 1'b0; fetch_req = 1'b0;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_reset_midop();
    @(negedge clock);
    working = 1'b1; fetch_req = 1'b1; fetch_addr = 9'h014;
    @(negedge clock);
    #1;
    n_checks++;
    if (fetch_gnt !== 1'b1) begin n_fail++; $display("FAIL midrst_gnt: got %b required 1", fetch_gnt); end
    @(negedge clock);
    fetch_req = 1'b0; working = 1'b0; rst_n = 1'b0;
    #1;
    n_checks++;
    if ({dbg_state, busy, ram_rd} !== 4'b0000) begin
      n_fail++; $display("FAIL midrst_clear: got state=%0d busy=%b rd=%b required 0 0 0", dbg_state, busy, ram_rd);
    end
    @(negedge clock);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      #1;
      n_checks++;
      if ({fetch_rvalid, host_rvalid, dbg_state} !== 4'b0000) begin
        n_fail++; $display("FAIL midrst_no_rvalid[%0d]: got frv=%b hrv=%b state=%0d required 0 0 0",
                           k, fetch_rvalid, host_rvalid, dbg_state);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    for (int i = 0; i < 512; i++) ref_mem[i] = pat(9'(i));
    test_reset();
    test_host_idle();
    test_fetch_burst();
    test_starvation();
    test_drain();
    test_reset_midop();
    n_checks++;
    if (host_exp_q.size() != 0 || fetch_exp_q.size() != 0) begin
      n_fail++; $display("FAIL outstanding_reads: got host=%0d fetch=%0d required 0 0",
                         host_exp_q.size(), fetch_exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
